// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared types and defaults for the SPI transaction arbiter
package spi_arb_pkg;

  localparam int NUM_REQ_DEF  = 4;
  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 8;
  localparam int TOUT_CYC_DEF = 1000;
  localparam int TOUT_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector starting the search at ptr
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  // Walk offsets from farthest to nearest so the requester closest to ptr wins last.
  always_comb begin
    int cand;
    logic [IDX_W-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    idx      = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = int'(ptr) + off;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        idx = cand_idx;
      end
    end
    grant = (req != '0) ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin arbiter sharing one SPI master; SPI_ARB_TIMEOUT_EN adds a transfer timeout
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
`ifdef SPI_ARB_TIMEOUT_EN
  ,
  parameter int TOUT_CYC = TOUT_CYC_DEF
`endif
) (
  input  logic                      clk,
  input  logic                      w_reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      spi_start,
  output logic [ADDR_W-1:0]         spi_addr,
  output logic [DATA_W-1:0]         spi_data,
  input  logic                      spi_ready,
  output logic                      busy,
  output logic                      tout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               start_q, start_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] done_onehot;
  logic [IDX_W-1:0]   ptr_next;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [TOUT_W-1:0]  cnt_q, cnt_d;
  logic               tout_q, tout_d;
  logic               tout_hit;

  assign tout_hit = (cnt_q == TOUT_W'(TOUT_CYC - 1));
`endif

  assign done_onehot = NUM_REQ'(1) << g_q;
  assign ptr_next    = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + IDX_W'(1);

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Next-state and pulse generation; pulses default low so each lasts one cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ready_d = '0;
    done_d  = '0;
    start_d = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tout_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (spi_ready && (req_valid != '0)) begin
          g_d     = pick_idx;
          ready_d = pick_grant;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
              addr_d = req_addr[i*ADDR_W +: ADDR_W];
              data_d = req_data[i*DATA_W +: DATA_W];
            end
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start_d = 1'b1;
        state_d = ST_WAIT_BUSY;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_WAIT_BUSY: begin
        if (!spi_ready) begin
          state_d = ST_WAIT_DONE;
`ifdef SPI_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (tout_hit) begin
          tout_d  = 1'b1;
          done_d  = done_onehot;
          ptr_d   = ptr_next;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TOUT_W'(1);
        end
`endif
      end
      ST_WAIT_DONE: begin
        if (spi_ready) begin
          done_d  = done_onehot;
          ptr_d   = ptr_next;
          state_d = ST_IDLE;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (tout_hit) begin
          tout_d  = 1'b1;
          done_d  = done_onehot;
          ptr_d   = ptr_next;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TOUT_W'(1);
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched transfer and registered pulses; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge w_reset) begin
    if (!w_reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      tout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      start_q <= start_d;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
`endif
    end
  end

  assign req_ready = ready_q;
  assign req_done  = done_q;
  assign spi_start = start_q;
  assign spi_addr  = addr_q;
  assign spi_data  = data_q;
  assign busy      = (state_q != ST_IDLE);
`ifdef SPI_ARB_TIMEOUT_EN
  assign tout_err  = tout_q;
`else
  assign tout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - directed scoreboard bench for spi_arbiter; SPI_ARB_TIMEOUT_EN enables the timeout case
module tb_spi_arbiter;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 8;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TOUT = 50;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   req_done;
  logic            spi_start;
  logic [AW-1:0]   spi_addr;
  logic [DW-1:0]   spi_data;
  logic            spi_ready;
  logic            busy;
  logic            tout_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic ready_int = 1'b1;
  logic force_low = 1'b0;
  logic stuck = 1'b0;
  int   m_len = 20;
  int   rise_cyc = -100;

  int exp_q[$];
  int done_q[$];
  int grant_cnt = 0;
  int grant_cyc = -100;
  logic [AW-1:0] lat_addr = '0;
  logic [DW-1:0] lat_data = '0;

  assign spi_ready = ready_int & ~force_low;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  spi_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW)
`ifdef SPI_ARB_TIMEOUT_EN
    ,
    .TOUT_CYC(TOUT)
`endif
  ) dut (
    .clk       (clk),
    .w_reset   (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .req_done  (req_done),
    .spi_start (spi_start),
    .spi_addr  (spi_addr),
    .spi_data  (spi_data),
    .spi_ready (spi_ready),
    .busy      (busy),
    .tout_err  (tout_err)
  );

  function automatic logic [7:0] addr_of(input int i);
    return 8'h81 + 8'(i * 17);
  endfunction

  function automatic logic [7:0] data_of(input int i);
    return 8'hAA + 8'(i * 17);
  endfunction

  function automatic int idx_of(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // which: 0 req_ready, 1 spi_start, 2 req_done, 3 not busy, 4 tout_err, 5 spi_ready low
  task automatic wait_sig(input int which, input int budget, input string tag, output int at);
    logic hit;
    at = -1;
    for (int k = 0; k < budget; k++) begin
      step();
      case (which)
        0: hit = (req_ready !== '0);
        1: hit = (spi_start === 1'b1);
        2: hit = (req_done !== '0);
        3: hit = (busy === 1'b0);
        4: hit = (tout_err === 1'b1);
        default: hit = (spi_ready === 1'b0);
      endcase
      if (hit) begin
        at = cyc;
        return;
      end
    end
    check({"wait_", tag}, 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_done"}, req_done, 0);
    check({tag, "_start"}, spi_start, 0);
    check({tag, "_addr"}, spi_addr, 0);
    check({tag, "_data"}, spi_data, 0);
    check({tag, "_tout"}, tout_err, 0);
  endtask

  // SPI master model: drops ready one cycle after start, holds it low m_len cycles.
  initial begin : master
    int phase;
    int hold;
    phase = 0;
    hold  = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        phase     = 0;
        ready_int = 1'b1;
      end else begin
        case (phase)
          0: if (spi_start === 1'b1 && !stuck) phase = 1;
          1: begin
            ready_int = 1'b0;
            hold      = m_len;
            phase     = 2;
          end
          default: begin
            hold--;
            if (hold == 0) begin
              ready_int = 1'b1;
              rise_cyc  = cyc;
              phase     = 0;
            end
          end
        endcase
      end
    end
  end

  // Scoreboard monitor: pops expected grants on req_ready, expected completions on req_done.
  initial begin : monitor
    int g;
    forever begin
      step();
      if (rst_n === 1'b1) begin
        if (req_ready !== '0) begin
          check("ready_onehot", 32'($onehot(req_ready)), 1);
          if (exp_q.size() == 0) begin
            check("unexpected_grant", req_ready, 0);
          end else begin
            g = exp_q.pop_front();
            check("grant_idx", idx_of(req_ready), g);
            check("grant_addr", spi_addr, addr_of(g));
            check("grant_data", spi_data, data_of(g));
            done_q.push_back(g);
          end
          grant_cnt++;
          grant_cyc = cyc;
          lat_addr  = spi_addr;
          lat_data  = spi_data;
        end else if (busy === 1'b1) begin
          check("addr_stable", spi_addr, lat_addr);
          check("data_stable", spi_data, lat_data);
        end
        if (spi_start === 1'b1) begin
          check("start_after_ready", cyc, grant_cyc + 1);
        end
        if (req_done !== '0) begin
          check("done_onehot", 32'($onehot(req_done)), 1);
          if (done_q.size() == 0) begin
            check("unexpected_done", req_done, 0);
          end else begin
            g = done_q.pop_front();
            check("done_idx", idx_of(req_done), g);
          end
          if (tout_err !== 1'b1) begin
            check("done_after_rise", cyc, rise_cyc + 1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n0;
    int t;
    int s;
    int base;
    rst_n     = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = addr_of(i);
      req_data[i*DW +: DW] = data_of(i);
    end
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single request from requester 0
    @(negedge clk);
    exp_q.push_back(0);
    req_valid = 4'b0001;
    n0 = cyc;
    wait_sig(0, 20, "single_ready", t);
    check("single_ready_lat", t, n0 + 1);
    check("single_ready_bit", req_ready, 4'b0001);
    check("single_addr", spi_addr, 8'h81);
    check("single_data", spi_data, 8'hAA);
    @(negedge clk);
    req_valid = '0;
    wait_sig(1, 20, "single_start", t);
    check("single_start_lat", t, n0 + 2);
    wait_sig(2, 100, "single_done", t);
    check("single_done_bit", req_done, 4'b0001);
    wait_sig(3, 20, "single_idle", t);

    // Gating: master busy in IDLE blocks the grant
    @(negedge clk);
    force_low = 1'b1;
    exp_q.push_back(1);
    req_valid = 4'b0010;
    repeat (5) begin
      step();
      check("gate_no_ready", req_ready, 0);
      check("gate_not_busy", busy, 0);
    end
    @(negedge clk);
    force_low = 1'b0;
    n0 = cyc;
    wait_sig(0, 20, "gate_ready", t);
    check("gate_ready_lat", t, n0 + 1);
    check("gate_ready_bit", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    wait_sig(2, 100, "gate_done", t);
    wait_sig(3, 20, "gate_idle", t);

    // Move pointer to 3 via requester 2
    @(negedge clk);
    exp_q.push_back(2);
    req_valid = 4'b0100;
    wait_sig(0, 20, "prep_ready", t);
    @(negedge clk);
    req_valid = '0;
    wait_sig(2, 100, "prep_done", t);
    wait_sig(3, 20, "prep_idle", t);

    // Wrap: ptr=3 with 1001 grants 3 then 0
    @(negedge clk);
    exp_q.push_back(3);
    exp_q.push_back(0);
    req_valid = 4'b1001;
    wait_sig(0, 20, "wrap_ready3", t);
    check("wrap_first", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = 4'b0001;
    wait_sig(2, 100, "wrap_done3", t);
    wait_sig(0, 20, "wrap_ready0", t);
    check("wrap_second", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    wait_sig(2, 100, "wrap_done0", t);
    wait_sig(3, 20, "wrap_idle", t);

    // Reset during WAIT_DONE
    @(negedge clk);
    exp_q.push_back(1);
    req_valid = 4'b0010;
    wait_sig(0, 20, "rst_ready", t);
    @(negedge clk);
    req_valid = '0;
    wait_sig(5, 20, "rst_spi_low", t);
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 4'b1111;
    #1 check_reset_outputs("midop_reset");
    done_q.delete();
    exp_q.delete();
    repeat (3) begin
      step();
      check("midop_no_done", req_done, 0);
    end
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    base = grant_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    n0 = cyc;

    // Contention after reset: 1111 held grants 0,1,2,3,0
    wait_sig(0, 20, "cont_first", t);
    check("cont_first_lat", t, n0 + 1);
    check("cont_first_bit", req_ready, 4'b0001);
    for (int k = 0; k < 1000; k++) begin
      if (grant_cnt >= base + 5) break;
      step();
    end
    check("cont_grants", grant_cnt - base, 5);
    @(negedge clk);
    req_valid = '0;
    wait_sig(3, 200, "cont_idle", t);
    check("cont_exp_empty", exp_q.size(), 0);
    check("cont_done_empty", done_q.size(), 0);

`ifdef SPI_ARB_TIMEOUT_EN
    // Timeout: master never responds
    @(negedge clk);
    stuck = 1'b1;
    exp_q.push_back(1);
    req_valid = 4'b0010;
    wait_sig(0, 20, "tout_ready", t);
    @(negedge clk);
    req_valid = '0;
    wait_sig(1, 20, "tout_start", s);
    wait_sig(4, 200, "tout_pulse", t);
    check("tout_lat", t, s + TOUT);
    check("tout_done_bit", req_done, 4'b0010);
    step();
    check("tout_idle", busy, 0);
    check("tout_pulse_len", tout_err, 0);
    stuck = 1'b0;
`endif

    check("final_exp_empty", exp_q.size(), 0);
    check("final_done_empty", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter: NUM_REQ, 4, number of requesters (2..8).
REQ-002 SHALL have parameter: ADDR_W, 8, SPI address width.
REQ-003 SHALL have parameter: DATA_W, 8, SPI write-data width.
REQ-004 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port: w_reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: req_valid  input  NUM_REQ  per-requester transaction request, level.
REQ-007 SHALL have port: req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port: req_data  input  NUM_REQ*DATA_W  packed write data, same packing.
REQ-009 SHALL have port: req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse.
REQ-010 SHALL have port: req_done  output  NUM_REQ  one-hot, one-cycle completion pulse.
REQ-011 SHALL have port: spi_start  output  1  one-cycle launch pulse to SPI master.
REQ-012 SHALL have port: spi_addr  output  ADDR_W  latched address to master.
REQ-013 SHALL have port: spi_data  output  DATA_W  latched data to master.
REQ-014 SHALL have port: spi_ready  input  1  master idle flag; high = idle, low = transfer in progress.
REQ-015 SHALL have port: busy  output  1  high in any state except IDLE.
REQ-016 SHALL have port: tout_err  output  1  one-cycle timeout pulse (tied 0 when feature is compiled out).

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-018 IDLE: if spi_ready=1 and any req_valid=1, SHALL select a winner g by round-robin starting at pointer ptr.
- On the next edge SHALL latch req_addr[g] and req_data[g] into spi_addr/spi_data, pulse req_ready[g], and enter ISSUE.
REQ-019 ISSUE: SHALL assert spi_start for exactly that one cycle, then enter WAIT_BUSY.
REQ-020 WAIT_BUSY: SHALL hold until spi_ready=0, then enter WAIT_DONE.
REQ-021 WAIT_DONE: on spi_ready=1, SHALL pulse req_done[g] for one cycle, set ptr=(g+1) mod NUM_REQ, and enter IDLE.
REQ-022 Request-to-start latency SHALL be 2 cycles: req_ready at N+1, spi_start at N+2.
REQ-023 spi_addr/spi_data SHALL stay stable from latch until the next grant.
REQ-024 req_valid deassertion after grant SHALL NOT abort the transfer.
REQ-025 Requests arriving while busy SHALL wait; no request SHALL be lost while req_valid is held.
REQ-026 Simultaneous requests SHALL be granted in order ptr, ptr+1, ... with wrap from NUM_REQ-1 to 0.
REQ-027 If spi_ready=0 in IDLE, SHALL NOT grant.
REQ-028 At most one req_ready bit and one req_done bit SHALL be high in any cycle.

Reset
REQ-029 On w_reset=0, SHALL immediately (asynchronously) enter IDLE with ptr=0 and spi_addr=spi_data=0.
- All pulses, busy and tout_err SHALL be 0.
REQ-030 Reset mid-transfer SHALL abandon the transfer without issuing req_done.
REQ-031 After release, SHALL start arbitration at the first rising edge.

Configuration
REQ-032 With macro SPI_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL run in WAIT_BUSY and WAIT_DONE.
- Counter SHALL clear on each state entry.
- Reaching parameter TOUT_CYC (default 1000) SHALL pulse tout_err and req_done[g], advance ptr, and return to IDLE.
REQ-033 Without SPI_ARB_TIMEOUT_EN, SHALL have no counter, tout_err SHALL be constant 0, and the FSM SHALL wait indefinitely.

Structure
REQ-034 Package spi_arb_pkg SHALL hold the FSM state enum, default widths and TOUT_CYC default.
REQ-035 SHALL contain one sub-module, rr_pick: combinational round-robin selector (req vector and ptr in; one-hot grant and index out).

Verification
REQ-036 Single request: req_valid=4'b0001, addr=8'h81, data=8'hAA; master drops spi_ready 1 cycle after start and holds it low 20 cycles.
- Required: req_ready[0] at N+1, spi_start at N+2, spi_addr=8'h81, spi_data=8'hAA, req_done[0] on the cycle after spi_ready rises.
REQ-037 Contention: req_valid=4'b1111 held, ptr=0 → grants in order 0,1,2,3,0; exactly one done per transfer.
REQ-038 Wrap: ptr=3 with req_valid=4'b1001 → grant 3, then 0.
REQ-039 Reset mid-op: w_reset=0 during WAIT_DONE → busy=0 and outputs 0 immediately, no req_done; next grant is requester 0.
REQ-040 Timeout (SPI_ARB_TIMEOUT_EN, TOUT_CYC=50): spi_ready stuck high after start → tout_err and req_done[g] at cycle 50 of WAIT_BUSY, FSM back in IDLE.
REQ-041 Gating: spi_ready=0 in IDLE with req_valid=4'b0010 → no grant until spi_ready=1, then req_ready[1] at the next edge.
